// File: rtl/midi_uart_rx_pkg.sv
// Shared MIDI definitions: receiver state encoding and protocol constants.
package midi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned MIDI_BAUD = 31_250;

    // Status bytes have the MSB set; data bytes do not.
    localparam logic [7:0] MIDI_STATUS_MASK = 8'h80;

endpackage

// File: rtl/midi_uart_rx_byte_fifo.sv
// Small circular byte FIFO with extra-MSB pointers for full/empty detection.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("byte_fifo DEPTH must be a power of two and at least 2");
    end

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A push while full still succeeds when the head is popped in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage and pointer update; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 serial receiver with mid-bit sampling, byte FIFO and error pulses.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 16_000_000,
    parameter int unsigned BAUD       = MIDI_BAUD,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          midi_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

    if ((CLK_FREQ % BAUD) != 0) begin : g_baud_check
        $error("CLK_FREQ must be an exact multiple of BAUD");
    end

    rx_state_t      state;
    rx_state_t      next_state;
    logic [1:0]     sync;
    logic           rx_s;
    logic           rx_prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     sr;
    logic           half_tick;
    logic           bit_tick;
    logic           push;
    logic           frame_err;
    logic           pop;
    logic           full;
    logic           empty;

    assign rx_s      = sync[1];
    assign half_tick = (cnt == CW'(HALF_BIT - 1));
    assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));

    // Two-flop synchroniser plus previous value for falling-edge detection; idle is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], midi_i};
            rx_prev <= rx_s;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (rx_prev && !rx_s)             next_state = START;
            START:     if (half_tick)                    next_state = rx_s ? IDLE : DATA;
            DATA:      if (bit_tick && (bit_cnt == 3'd7)) next_state = STOP;
            STOP:      if (bit_tick)                     next_state = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s)                         next_state = IDLE;
            default:                                     next_state = IDLE;
        endcase
    end

    // Stop-bit outcome: push a good byte or flag a framing error.
    always_comb begin
        push      = 1'b0;
        frame_err = 1'b0;
        if ((state == STOP) && bit_tick) begin
            push      = rx_s;
            frame_err = !rx_s;
        end
    end

    // Bit-period timing, bit counting and LSB-first shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            bit_cnt <= '0;
            sr      <= '0;
        end else begin
            case (state)
                START: cnt <= half_tick ? '0 : cnt + 1'b1;
                DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 3'd1;
                        sr      <= {rx_s, sr[7:1]};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: cnt <= bit_tick ? '0 : cnt + 1'b1;
                default: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;

    // Registered single-cycle status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_err;
            overrun_o   <= push && full && !pop;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .din   (sr),
        .full  (full),
        .pop   (pop),
        .dout  (data_o),
        .empty (empty),
        .level (level_o)
    );

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed self-checking bench for midi_uart_rx at default parameters (512 clocks per bit).
module tb_midi_uart_rx;
    import midi_pkg::*;

    localparam int unsigned CPB = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic       midi;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic [2:0] level;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    logic [7:0]  pop_q[$];
    int unsigned pop_cyc_q[$];
    int unsigned ferr_n = 0, ovr_n = 0, valid_n = 0;
    int unsigned ferr_cyc = 0, ovr_cyc = 0;

    midi_uart_rx dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .midi_i      (midi),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (ferr),
        .overrun_o   (ovr),
        .level_o     (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record handshakes and pulses away from the active edge.
    always @(negedge clk) begin
        if (valid && ready) begin
            pop_q.push_back(data);
            pop_cyc_q.push_back(cyc);
        end
        if (valid) valid_n++;
        if (ferr) begin
            ferr_n++;
            ferr_cyc = cyc;
        end
        if (ovr) begin
            ovr_n++;
            ovr_cyc = cyc;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, expected finish before 5ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive {stop, data, start} LSB first, one bit per CPB clocks, for ncyc clocks.
    task automatic drive_bits(input logic [9:0] frame, input int unsigned ncyc);
        for (int unsigned c = 0; c < ncyc; c++) begin
            if ((c % CPB) == 0) midi = frame[c / CPB];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        drive_bits({stop, d, 1'b0}, 10 * CPB);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp, output int unsigned pcyc);
        logic [31:0] got;
        got  = 32'hDEAD;
        pcyc = 0;
        if (pop_q.size() > 0) begin
            got  = 32'(pop_q.pop_front());
            pcyc = pop_cyc_q.pop_front();
        end
        chk(tag, got, 32'(exp));
    endtask

    initial begin
        int unsigned t0, f0, o0, v0, pc;

        rst   = 1'b1;
        midi  = 1'b1;
        ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_data",  32'(data),  32'h00);
        chk("rst_ferr",  32'(ferr),  32'd0);
        chk("rst_ovr",   32'(ovr),   32'd0);
        rst = 1'b0;
        idle(20);

        // Single byte 0x90 with consumer always ready.
        ready = 1'b1;
        t0 = cyc;
        v0 = valid_n;
        send(8'h90, 1'b1);
        idle(50);
        pop_chk("single_data", 8'h90, pc);
        chk("single_latency", pc - t0, 32'd4867);
        chk("single_valid_cycles", valid_n - v0, 32'd1);
        chk("single_no_ferr", ferr_n, 32'd0);
        chk("single_no_ovr", ovr_n, 32'd0);

        // 100-cycle low glitch must be rejected at the half-bit check.
        v0 = valid_n;
        midi = 1'b0;
        idle(100);
        midi = 1'b1;
        idle(600);
        chk("glitch_no_valid", valid_n - v0, 32'd0);
        chk("glitch_no_ferr", ferr_n, 32'd0);
        chk("glitch_state", 32'(dut.state), 32'(IDLE));

        // 0x3C with a zero stop bit followed by a 3-bit-time break.
        f0 = ferr_n;
        t0 = cyc;
        send(8'h3C, 1'b0);
        chk("ferr_wait_state", 32'(dut.state), 32'(WAIT_IDLE));
        idle(3 * CPB);
        midi = 1'b1;
        idle(CPB);
        chk("ferr_pulses", ferr_n - f0, 32'd1);
        chk("ferr_timing", ferr_cyc - t0, 32'd4867);
        chk("ferr_no_push", 32'(pop_q.size()), 32'd0);
        chk("ferr_level", 32'(level), 32'd0);
        chk("ferr_state", 32'(dut.state), 32'(IDLE));
        send(8'h45, 1'b1);
        idle(50);
        pop_chk("after_ferr_data", 8'h45, pc);
        chk("after_ferr_pulses", ferr_n, 32'd1);

        // Overrun: consumer stalled, five back-to-back bytes.
        ready = 1'b0;
        o0 = ovr_n;
        for (int unsigned i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1);
        end
        chk("ovr_level4", 32'(level), 32'd4);
        chk("ovr_head", 32'(data), 32'h01);
        chk("ovr_none_yet", ovr_n - o0, 32'd0);
        t0 = cyc;
        send(8'h05, 1'b1);
        chk("ovr_level_still4", 32'(level), 32'd4);
        chk("ovr_pulses", ovr_n - o0, 32'd1);
        chk("ovr_timing", ovr_cyc - t0, 32'd4867);

        // Full FIFO with a pop in exactly the stop-sample push cycle.
        o0 = ovr_n;
        t0 = cyc;
        fork
            send(8'h06, 1'b1);
            begin
                repeat (4866) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        pop_chk("simpop_head", 8'h01, pc);
        chk("simpop_cycle", pc - t0, 32'd4866);
        chk("simpop_no_ovr", ovr_n - o0, 32'd0);
        chk("simpop_level", 32'(level), 32'd4);
        chk("simpop_next_head", 32'(data), 32'h02);
        ready = 1'b1;
        idle(10);
        ready = 1'b0;
        pop_chk("drain_0", 8'h02, pc);
        pop_chk("drain_1", 8'h03, pc);
        pop_chk("drain_2", 8'h04, pc);
        pop_chk("drain_3", 8'h06, pc);
        chk("drain_extra", 32'(pop_q.size()), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_valid", 32'(valid), 32'd0);

        // Reset in the middle of data bit 4 of 0xAA with a byte already queued.
        send(8'h7E, 1'b1);
        idle(10);
        chk("pre_rst_level", 32'(level), 32'd1);
        chk("pre_rst_data", 32'(data), 32'h7E);
        drive_bits({1'b1, 8'hAA, 1'b0}, 5 * CPB + CPB / 2);
        chk("pre_rst_state", 32'(dut.state), 32'(DATA));
        rst  = 1'b1;
        midi = 1'b1;
        #1;
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_data", 32'(data), 32'h00);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        #1 rst = 1'b0;
        idle(100);
        chk("post_rst_state", 32'(dut.state), 32'(IDLE));
        chk("post_rst_valid", 32'(valid), 32'd0);
        ready = 1'b1;
        send(8'h55, 1'b1);
        idle(50);
        pop_chk("post_rst_data", 8'h55, pc);
        chk("post_rst_extra", 32'(pop_q.size()), 32'd0);
        chk("final_ferr_total", ferr_n, 32'd1);
        chk("final_ovr_total", ovr_n, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
